ps2_scancode_decoder: RTL
=========================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 receiver.
- Consumes each 11-bit frame the receiver delivers (data_valid strobe plus sda_to_do frame) and validates it: start, odd parity and stop bits.
- Tracks the set-2 make/break/extended prefix sequence.
- Maintains a held-key bitmap for the 8 piano keys and queues press/release events in a small FIFO for the display/tone logic.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- data_valid  input  1  one-cycle strobe: sda_to_do holds a complete frame.
- sda_to_do  input  11  [0]=start, [8:1]=data LSB-first, [9]=odd parity, [10]=stop.
- ev_ready  input  1  consumer accepts the head event.
- ev_valid  output  1  FIFO non-empty.
- ev_key  output  3  key index of the head event.
- ev_press  output  1  1=press, 0=release.
- keys_held  output  8  bit i=1 while key i is held.
- frame_err  output  1  one-cycle pulse on a rejected frame.
- err_cnt  output  ERR_W  count of rejected frames; saturates at all-ones.
- fifo_ovf  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset: rst sampled high at a clock edge clears all outputs to 0, FSM=IDLE, FIFO empty, err_cnt=0, fifo_ovf=0. rst overrides any concurrent data_valid or ev_ready.
- Frame check, in the cycle data_valid=1:
  - Valid iff sda_to_do[0]=0, sda_to_do[10]=1, and XOR of [9:1] = 1 (odd parity).
  - Invalid: frame_err pulses the next cycle; err_cnt increments, saturating; FSM forced to IDLE; no event; keys_held unchanged.
- Byte = sda_to_do[8:1]. FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: E0->EXT; F0->BRK; mapped key code->make; any other byte->IDLE, ignored.
  - BRK: mapped key code->break; any byte other than E0/F0->IDLE; E0/F0 in BRK->IDLE, discarded as a protocol glitch.
  - EXT: F0->EXT_BRK; any other byte->IDLE, extended make ignored.
  - EXT_BRK: any byte->IDLE, extended break ignored.
- Key map, set-2: 1C->0, 1B->1, 23->2, 2B->3, 34->4, 33->5, 3B->6, 42->7. All other codes are unmapped.
- Make of key k:
  - Bit k already set (typematic repeat): no event.
  - Otherwise: set bit k and push {k,1}.
- Break of key k:
  - Bit k clear: no event.
  - Otherwise: clear bit k and push {k,0}.
- Latency: keys_held and FIFO contents are updated at the edge sampling data_valid. The new keys_held value and ev_valid are visible the following cycle, i.e. 1-cycle latency.
- FIFO:
  - Show-ahead: ev_key/ev_press are valid whenever ev_valid=1.
  - Pop on ev_valid & ev_ready.
  - ev_ready with ev_valid=0 has no effect.
- Full FIFO, push requested:
  - With a concurrent pop: both occur and the count is unchanged.
  - Without a pop: the event is dropped and fifo_ovf is set, sticky until rst.
  - keys_held is still updated either way, so the bitmap stays truthful.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is held in a counter of width log2(FIFO_DEPTH)+1.
- data_valid asserted on consecutive cycles: each frame is processed independently.

Test Plan:
- Reset, then frames 1C, F0, 1C (valid parity), consumer always ready:
  - ev_valid pulses twice: {0,1} then {0,0}.
  - keys_held goes 0x01 then back to 0x00.
- Frames 23, 23, 23 then F0, 23:
  - Exactly one press {2,1} and one release {2,0}; keys_held=0x04 between them.
- Frame 1C with the parity bit flipped:
  - frame_err pulses once; err_cnt=1; keys_held=0x00; no event.
  - A following valid 1C is accepted as a press.
- E0, 1C then E0, F0, 1C:
  - No events; keys_held stays 0x00; FSM back in IDLE, so a following 1B produces {1,1}.
- ev_ready=0, presses of keys 0..4 (FIFO_DEPTH=4):
  - First four events queued; fifo_ovf=1; keys_held=0x1F.
  - Then ev_ready=1: events for keys 0,1,2,3 are drained in order.
- rst asserted for one cycle in the middle of a F0 prefix with a full FIFO:
  - Next cycle: ev_valid=0, keys_held=0, fifo_ovf=0, err_cnt=0.
  - A following 1C is treated as a make and yields {0,1}.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: validates PS/2 frames, decodes set-2 make/break for 8 piano keys, queues events
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [10:0]      sda_to_do,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [2:0]       ev_key,
  output logic             ev_press,
  output logic [7:0]       keys_held,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fifo_ovf
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t state, nxt;
  logic [7:0] b;
  logic ok, hit, mk, brk_ev, push_req, push, pop, full;
  logic [2:0] k;
  logic [AW:0] cnt;
  logic [AW-1:0] wp, rp;
  logic [3:0] mem [FIFO_DEPTH];
  assign b = sda_to_do[8:1];
  assign ok = ~sda_to_do[0] & sda_to_do[10] & (^sda_to_do[9:1]);
  always_comb begin
    hit = 1'b1;
    k = 3'd0;
    case (b)
      8'h1C: k = 3'd0;
      8'h1B: k = 3'd1;
      8'h23: k = 3'd2;
      8'h2B: k = 3'd3;
      8'h34: k = 3'd4;
      8'h33: k = 3'd5;
      8'h3B: k = 3'd6;
      8'h42: k = 3'd7;
      default: hit = 1'b0;
    endcase
  end
  always_comb begin
    nxt = state;
    if (data_valid)
      nxt = !ok ? IDLE :
            state == IDLE ? (b == 8'hE0 ? EXT : b == 8'hF0 ? BRK : IDLE) :
            state == EXT  ? (b == 8'hF0 ? EXT_BRK : IDLE) :
            IDLE;
  end
  // typematic repeats and breaks of unheld keys are filtered here, before the FIFO
  assign mk = data_valid & ok & (state == IDLE) & hit & ~keys_held[k];
  assign brk_ev = data_valid & ok & (state == BRK) & hit & keys_held[k];
  assign push_req = mk | brk_ev;
  assign ev_valid = cnt != '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop = ev_valid & ev_ready;
  assign push = push_req & (~full | pop);
  assign ev_key = ev_valid ? mem[rp][3:1] : 3'd0;
  assign ev_press = ev_valid & mem[rp][0];
  always_ff @(posedge clk)
    if (push) mem[wp] <= {k, mk};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      keys_held <= '0;
      frame_err <= 1'b0;
      err_cnt <= '0;
      fifo_ovf <= 1'b0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      state <= nxt;
      frame_err <= data_valid & ~ok;
      if (data_valid & ~ok & ~&err_cnt) err_cnt <= err_cnt + 1'b1;
      if (mk) keys_held[k] <= 1'b1;
      if (brk_ev) keys_held[k] <= 1'b0;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push_req & full & ~pop) fifo_ovf <= 1'b1;
    end
  end
endmodule
